// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared period counter (edge- or center-aligned) with
// per-channel duty compare; period, mode and duties are double-buffered.
module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      load,
  input  logic                      mode_in,
  input  logic [WIDTH-1:0]          period_in,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_end,
  output logic [WIDTH-1:0]          cnt_out
);

  localparam logic [0:0]       DIR_UP   = 1'b0;
  localparam logic [0:0]       DIR_DOWN = 1'b1;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_step;
  logic [0:0]       dir_q, dir_d, dir_step;
  logic [WIDTH-1:0] period_sh_q, period_sh_d, period_act_q, period_act_d;
  logic             mode_sh_q, mode_sh_d, mode_act_q, mode_act_d;
  logic             period_end_q, period_end_d;
  logic             boundary;

  always_comb begin
    cnt_step = cnt_q;
    dir_step = dir_q;
    if (!mode_act_q) begin
      cnt_step = (cnt_q >= period_act_q) ? '0 : cnt_q + CNT_ONE;
      dir_step = DIR_UP;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q < period_act_q) begin
        cnt_step = cnt_q + CNT_ONE;
      end else begin
        cnt_step = cnt_q - CNT_ONE;
        dir_step = DIR_DOWN;
      end
    end else begin
      cnt_step = cnt_q - CNT_ONE;
      if (cnt_q <= CNT_ONE) begin
        cnt_step = '0;
        dir_step = DIR_UP;
      end
    end

    // P = 0 makes every enabled cycle a boundary; the stepper result is ignored then.
    boundary = ena && ((period_act_q == '0) || ((cnt_q != '0) && (cnt_step == '0)));

    cnt_d = cnt_q;
    dir_d = dir_q;
    if (ena) begin
      cnt_d = cnt_step;
      dir_d = dir_step;
    end
    if (boundary) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end

    period_end_d = boundary;

    period_sh_d = load ? period_in : period_sh_q;
    mode_sh_d   = load ? mode_in : mode_sh_q;
    // Active side takes the pre-load shadow, so a coincident load waits one more period.
    period_act_d = boundary ? period_sh_q : period_act_q;
    mode_act_d   = boundary ? mode_sh_q : mode_act_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      period_sh_q  <= '1;
      period_act_q <= '1;
      mode_sh_q    <= 1'b0;
      mode_act_q   <= 1'b0;
      period_end_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      mode_sh_q    <= mode_sh_d;
      mode_act_q   <= mode_act_d;
      period_end_q <= period_end_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;
      logic             pwm_q, pwm_d;

      always_comb begin
        duty_sh_d  = load ? duty_in[gi*WIDTH +: WIDTH] : duty_sh_q;
        duty_act_d = boundary ? duty_sh_q : duty_act_q;
        pwm_d      = ena && (cnt_q < duty_act_q);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          duty_sh_q  <= '0;
          duty_act_q <= '0;
          pwm_q      <= 1'b0;
        end else begin
          duty_sh_q  <= duty_sh_d;
          duty_act_q <= duty_act_d;
          pwm_q      <= pwm_d;
        end
      end

      assign pwm_out[gi] = pwm_q;
    end
  endgenerate

  assign period_end = period_end_q;
  assign cnt_out    = cnt_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: counts high cycles per channel and period_end
// strobes over windows aligned to period boundaries.
module tb_pwm_multi;
  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;

  logic                      clk;
  logic                      rst_n;
  logic                      ena;
  logic                      load;
  logic                      mode_in;
  logic [WIDTH-1:0]          period_in;
  logic [CHANNELS*WIDTH-1:0] duty_in;
  logic [CHANNELS-1:0]       pwm_out;
  logic                      period_end;
  logic [WIDTH-1:0]          cnt_out;

  pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .load       (load),
    .mode_in    (mode_in),
    .period_in  (period_in),
    .duty_in    (duty_in),
    .pwm_out    (pwm_out),
    .period_end (period_end),
    .cnt_out    (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int          hi_cnt [CHANNELS];
  int          pe_cnt;
  int          sample_idx;
  logic [31:0] pat0;
  int          first_cnt;
  int          first_pwm;
  int          last_pe;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < CHANNELS; c++) hi_cnt[c] = 0;
    pe_cnt     = 0;
    sample_idx = 0;
    pat0       = '0;
  endtask

  // Each step waits for the next falling edge (mid-cycle) and samples outputs.
  task automatic run_count(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int c = 0; c < CHANNELS; c++) hi_cnt[c] += int'(pwm_out[c]);
      pe_cnt += int'(period_end);
      if (sample_idx < 32) pat0[sample_idx] = pwm_out[0];
      if (sample_idx == 0) begin
        first_cnt = int'(cnt_out);
        first_pwm = int'(pwm_out);
      end
      last_pe = int'(period_end);
      sample_idx++;
    end
  endtask

  task automatic do_load(input logic [WIDTH-1:0] p, input logic m,
                         input logic [CHANNELS*WIDTH-1:0] d);
    period_in = p;
    mode_in   = m;
    duty_in   = d;
    load      = 1'b1;
    run_count(1);
    load      = 1'b0;
  endtask

  task automatic wait_pe(input string tag, input int max_cycles);
    bit seen = 0;
    for (int k = 0; k < max_cycles && !seen; k++) begin
      @(negedge clk);
      if (period_end) seen = 1;
    end
    if (!seen) check(tag, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; load = 1'b0;
    mode_in = 1'b0; period_in = '0; duty_in = '0;
    clear_counts();
    first_cnt = 0; first_pwm = 0; last_pe = 0;

    // Reset and default period of 256
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cnt", int'(cnt_out), 0);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_pe", int'(period_end), 0);
    ena = 1'b1;
    clear_counts();
    run_count(256);
    check("dflt_pe_count", pe_cnt, 1);
    check("dflt_pe_at_256", last_pe, 1);
    check("dflt_pwm_hi", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);

    // Edge mode P=9, duty ch3..ch0 = 255,10,3,0
    do_load(8'd9, 1'b0, {8'd255, 8'd10, 8'd3, 8'd0});
    wait_pe("edge_wait_pe", 300);
    check("edge_cnt_at_boundary", int'(cnt_out), 0);
    clear_counts();
    run_count(10);
    check("edge_lag_cnt", first_cnt, 1);
    check("edge_lag_pwm", first_pwm, 4'b1110);
    check("edge_ch0_hi", hi_cnt[0], 0);
    check("edge_ch1_hi", hi_cnt[1], 3);
    check("edge_ch2_hi", hi_cnt[2], 10);
    check("edge_ch3_hi", hi_cnt[3], 10);
    check("edge_pe_count", pe_cnt, 1);
    check("edge_pe_last", last_pe, 1);

    // Double buffering: load D=7 mid-period at cnt 5
    clear_counts();
    run_count(5);
    check("dbuf_cnt_at_load", int'(cnt_out), 5);
    do_load(8'd9, 1'b0, {8'd255, 8'd10, 8'd7, 8'd0});
    run_count(4);
    check("dbuf_old_period_ch1", hi_cnt[1], 3);
    check("dbuf_old_pe", pe_cnt, 1);
    clear_counts();
    run_count(9);
    check("dbuf_cnt_before_bnd", int'(cnt_out), 9);
    do_load(8'd9, 1'b0, {8'd255, 8'd10, 8'd2, 8'd0});
    check("dbuf_new_period_ch1", hi_cnt[1], 7);
    check("dbuf_load_on_bnd_pe", last_pe, 1);
    clear_counts();
    run_count(10);
    check("dbuf_delayed_ch1", hi_cnt[1], 7);
    clear_counts();
    run_count(10);
    check("dbuf_applied_ch1", hi_cnt[1], 2);
    check("dbuf_applied_pe", pe_cnt, 1);

    // Enable gating at cnt 4 for 7 cycles
    clear_counts();
    run_count(4);
    check("gate_cnt_before", int'(cnt_out), 4);
    check("gate_pre_ch1", hi_cnt[1], 2);
    ena = 1'b0;
    clear_counts();
    run_count(7);
    check("gate_pwm_hi", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);
    check("gate_pe", pe_cnt, 0);
    check("gate_cnt_frozen", int'(cnt_out), 4);
    ena = 1'b1;
    clear_counts();
    run_count(6);
    check("gate_resume_cnt", first_cnt, 5);
    check("gate_post_ch1", hi_cnt[1], 0);
    check("gate_post_ch2", hi_cnt[2], 6);
    check("gate_post_pe", pe_cnt, 1);
    check("gate_post_pe_last", last_pe, 1);

    // Center mode P=4, ch0 D=2
    do_load(8'd4, 1'b1, {8'd0, 8'd0, 8'd0, 8'd2});
    wait_pe("ctr_wait_pe", 20);
    clear_counts();
    run_count(8);
    check("ctr_ch0_hi", hi_cnt[0], 3);
    check("ctr_ch0_pattern", int'(pat0[7:0]), 8'b1000_0011);
    check("ctr_pe_count", pe_cnt, 1);
    check("ctr_pe_last", last_pe, 1);
    clear_counts();
    run_count(8);
    check("ctr_second_ch0_hi", hi_cnt[0], 3);
    check("ctr_second_pe", pe_cnt, 1);

    // Degenerate P=0
    do_load(8'd0, 1'b0, {8'd0, 8'd0, 8'd0, 8'd1});
    wait_pe("p0_wait_pe", 20);
    clear_counts();
    run_count(5);
    check("p0_d1_ch0_hi", hi_cnt[0], 5);
    check("p0_d1_pe", pe_cnt, 5);
    check("p0_cnt", int'(cnt_out), 0);
    do_load(8'd0, 1'b0, {8'd0, 8'd0, 8'd0, 8'd0});
    run_count(2);
    clear_counts();
    run_count(5);
    check("p0_d0_ch0_hi", hi_cnt[0], 0);
    check("p0_d0_pe", pe_cnt, 5);

    // Asynchronous reset mid-cycle while an output is high
    do_load(8'd0, 1'b0, {8'd0, 8'd0, 8'd0, 8'd1});
    run_count(3);
    check("arst_pre_pwm0", int'(pwm_out[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pwm", int'(pwm_out), 0);
    check("arst_pe", int'(period_end), 0);
    check("arst_cnt", int'(cnt_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    run_count(20);
    check("arst_after_pe", pe_cnt, 0);
    check("arst_after_pwm", hi_cnt[0], 0);
    check("arst_after_cnt", int'(cnt_out), 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
